// File: rtl/dot_product_accumulator.sv
// Multiply-accumulate back end for the Wallace-tree multiplier.
// Sums a vector of 8-bit products and returns the total over a valid/ready handshake.
module dot_product_accumulator #(
   parameter int MAX_LEN = 16,
   parameter int ACC_W   = 12,
   parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] vec_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       prod_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [LEN_W-1:0] count;
   logic             ovf_acc;
   logic [LEN_W-1:0] len_eff;
   logic [ACC_W:0]   sum;
   logic             accept;

   assign in_ready = (state == ACCUM);
   assign accept   = in_valid & in_ready;
   assign sum      = {1'b0, acc} + (ACC_W+1)'(prod_in);

   // Zero-length requests still consume one beat; long ones clamp.
   always_comb begin
      len_eff = vec_len;
      if (vec_len == '0)
         len_eff = LEN_W'(1);
      else if (vec_len > LEN_W'(MAX_LEN))
         len_eff = LEN_W'(MAX_LEN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         ovf_acc   <= 1'b0;
         out_valid <= 1'b0;
         acc_out   <= '0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  count   <= len_eff;
                  acc     <= '0;
                  ovf_acc <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc     <= sum[ACC_W-1:0];
                  ovf_acc <= ovf_acc | sum[ACC_W];
                  count   <= count - 1'b1;
                  if (count == LEN_W'(1)) begin
                     acc_out   <= sum[ACC_W-1:0];
                     overflow  <= ovf_acc | sum[ACC_W];
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator.
// Runs a 12-bit and an 8-bit instance side by side against a plain-arithmetic model.
module tb_dot_product_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  vec_len;
   logic        in_valid;
   logic [7:0]  prod_in;
   logic        out_ready;

   logic        in_ready12, out_valid12, overflow12, busy12;
   logic [11:0] acc12;
   logic        in_ready8, out_valid8, overflow8, busy8;
   logic [7:0]  acc8;

   int n_cmp = 0;
   int n_bad = 0;
   int prods[16];
   int gaps[16];

   always #5 clk = ~clk;

   dot_product_accumulator #(.MAX_LEN(16), .ACC_W(12)) dut12 (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
      .in_valid(in_valid), .in_ready(in_ready12), .prod_in(prod_in),
      .out_valid(out_valid12), .out_ready(out_ready), .acc_out(acc12),
      .overflow(overflow12), .busy(busy12)
   );

   dot_product_accumulator #(.MAX_LEN(16), .ACC_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
      .in_valid(in_valid), .in_ready(in_ready8), .prod_in(prod_in),
      .out_valid(out_valid8), .out_ready(out_ready), .acc_out(acc8),
      .overflow(overflow8), .busy(busy8)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int beats_of(input int vl);
      if (vl == 0) return 1;
      if (vl > 16) return 16;
      return vl;
   endfunction

   function automatic int ref_sum(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += prods[i];
      return s;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, ".in_ready"}, in_ready12, 0);
      chk({tag, ".out_valid"}, out_valid12, 0);
      chk({tag, ".acc_out"}, acc12, 0);
      chk({tag, ".overflow"}, overflow12, 0);
      chk({tag, ".busy"}, busy12, 0);
      chk({tag, ".acc8"}, acc8, 0);
   endtask

   // One full transaction: start, beats (with gaps), hold, handshake.
   task automatic run_vec(input string tag, input int vl, input int hold_cyc,
                          input bit start_at_ready);
      int n;
      int total;
      int waited;
      n     = beats_of(vl);
      total = ref_sum(n);
      vec_len = 5'(vl);
      start   = 1'b1;
      tick;
      start   = 1'b0;
      vec_len = '0;
      chk({tag, ".busy_go"}, busy12, 1);
      chk({tag, ".ready_go"}, in_ready12, 1);
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < gaps[i]; g++) begin
            in_valid = 1'b0;
            prod_in  = 8'($urandom);
            tick;
            chk({tag, ".gap_ready"}, in_ready12, 1);
            chk({tag, ".gap_valid"}, out_valid12, 0);
         end
         in_valid = 1'b1;
         prod_in  = 8'(prods[i]);
         tick;
      end
      in_valid = 1'b0;
      chk({tag, ".latency"}, out_valid12, 1);
      chk({tag, ".hold_ready"}, in_ready12, 0);
      waited = 0;
      while (!out_valid12 && waited < 20) begin
         tick;
         waited++;
      end
      chk({tag, ".acc12"}, acc12, total % 4096);
      chk({tag, ".ovf12"}, overflow12, (total >= 4096) ? 1 : 0);
      chk({tag, ".acc8"}, acc8, total % 256);
      chk({tag, ".ovf8"}, overflow8, (total >= 256) ? 1 : 0);
      for (int h = 0; h < hold_cyc; h++) begin
         start = h[0];
         tick;
         start = 1'b0;
         chk({tag, ".hold_valid"}, out_valid12, 1);
         chk({tag, ".hold_acc"}, acc12, total % 4096);
         chk({tag, ".hold_rdy"}, in_ready12, 0);
      end
      out_ready = 1'b1;
      start     = start_at_ready;
      tick;
      out_ready = 1'b0;
      start     = 1'b0;
      chk({tag, ".done_valid"}, out_valid12, 0);
      chk({tag, ".done_busy"}, busy12, 0);
      chk({tag, ".retain"}, acc12, total % 4096);
      if (start_at_ready) begin
         tick;
         chk({tag, ".start_lost_busy"}, busy12, 0);
         chk({tag, ".start_lost_rdy"}, in_ready12, 0);
      end
      for (int i = 0; i < 16; i++) gaps[i] = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; vec_len = '0;
      in_valid = 1'b0; prod_in = '0; out_ready = 1'b0;
      for (int i = 0; i < 16; i++) gaps[i] = 0;
      tick; tick;
      chk_zero("reset");
      rst_n = 1'b1;
      tick;

      // inputs ignored in IDLE
      in_valid = 1'b1; prod_in = 8'd99;
      tick; tick;
      chk("idle.in_ready", in_ready12, 0);
      chk("idle.busy", busy12, 0);
      in_valid = 1'b0;

      // abort mid-ACCUM after three beats
      vec_len = 5'd5; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; prod_in = 8'd200;
         tick;
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_zero("abort");
      tick;
      rst_n = 1'b1;
      tick;

      prods[0] = 5; prods[1] = 6;
      run_vec("clean", 2, 0, 1'b0);

      prods[0] = 225; prods[1] = 15; prods[2] = 0; prods[3] = 14;
      run_vec("vec4", 4, 0, 1'b0);

      for (int i = 0; i < 16; i++) prods[i] = 225;
      run_vec("full16", 16, 0, 1'b0);

      prods[0] = 1; prods[1] = 2; prods[2] = 4;
      gaps[1] = 2; gaps[2] = 1;
      run_vec("gaps", 3, 0, 1'b0);

      prods[0] = 77; prods[1] = 88;
      run_vec("hold5", 2, 5, 1'b0);

      prods[0] = 42; prods[1] = 100;
      run_vec("len0", 0, 1, 1'b0);

      for (int i = 0; i < 16; i++) prods[i] = 10 + i;
      run_vec("len31", 31, 0, 1'b1);

      for (int r = 0; r < 10; r++) begin
         int vl;
         vl = $urandom_range(0, 20);
         for (int i = 0; i < 16; i++) begin
            prods[i] = $urandom_range(0, 15) * $urandom_range(0, 15);
            gaps[i]  = $urandom_range(0, 2);
         end
         run_vec($sformatf("rand%0d", r), vl, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
